// File: rtl/seq_shift_add_multiplier_if.sv
// Start/done handshake bundle for the sequential shift-and-add multiplier.
// The requester takes the master side and the multiplier takes the slave side.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned shift-and-add multiplier. One WIDTH-bit ripple-carry adder is reused
// for WIDTH cycles to build a 2*WIDTH-bit product behind a start/done handshake.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    seq_shift_add_multiplier_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH:0]       carry;
    logic [2*WIDTH-1:0]   acc_d;

    assign hi     = acc_q[2*WIDTH-1:WIDTH];
    assign lo     = acc_q[WIDTH-1:0];
    assign addend = lo[0] ? mcand_q : '0;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_adder
        full_adder u_fa (
            .a_i (hi[i]),
            .b_i (addend[i]),
            .c_i (carry[i]),
            .s_o (sum[i]),
            .c_o (carry[i+1])
        );
    end

    // The final carry becomes the top bit of hi once the partial sum shifts right.
    assign acc_d = {carry[WIDTH], sum, lo[WIDTH-1:1]};

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q <= bus.a;
                        acc_q   <= {{WIDTH{1'b0}}, bus.b};
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        product_q <= acc_d;
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule
